// File: rtl/ritc_dac_servo_arbiter_if.sv
// Shared bus between the DAC requesters (RITC0/RITC1 servo loops, GLITCBUS),
// the DAC arbiter, and the RITC_Dual_DAC loader port.
interface ritc_dac_servo_arbiter_if #(
  parameter int NREQ = 3
);
  // Handshake: req[k] and its addr/chan/value/update are held until gnt[k]
  // pulses for one cycle, which is the cycle the data is captured; dac_wr and
  // dac_update are one-cycle strobes the loader acknowledges by raising
  // dac_busy and later dropping it when the load has finished.
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_addr;
  logic [6*NREQ-1:0]  req_chan;
  logic [12*NREQ-1:0] req_value;
  logic [NREQ-1:0]    req_update;
  logic [NREQ-1:0]    gnt;
  logic               dac_addr;
  logic [5:0]         dac_chan;
  logic [11:0]        dac_value;
  logic               dac_wr;
  logic               dac_update;
  logic               dac_busy;

  modport master (
    output req, req_addr, req_chan, req_value, req_update, dac_busy,
    input  gnt, dac_addr, dac_chan, dac_value, dac_wr, dac_update
  );

  modport slave (
    input  req, req_addr, req_chan, req_value, req_update, dac_busy,
    output gnt, dac_addr, dac_chan, dac_value, dac_wr, dac_update
  );
endinterface

// File: rtl/ritc_dac_servo_arbiter.sv
// Round-robin arbiter/sequencer sharing the RITC DAC loader port: one write,
// an optional latch strobe, busy handshake and sticky loader-timeout flag.
module ritc_dac_servo_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  ritc_dac_servo_arbiter_if.slave  bus,
  input  logic                     err_clr_i,
  output logic                     err_o,
  output logic                     busy_o,
  output logic [15:0]              wr_count_o,
  output logic [2:0]               dbg_state_o
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_UPD     = 3'd4,
    S_UPD_HI  = 3'd5,
    S_UPD_LO  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   last_q, last_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            addr_q, addr_d;
  logic [5:0]      chan_q, chan_d;
  logic [11:0]     value_q, value_d;
  logic            upd_q, upd_d;
  logic            wr_q, wr_d;
  logic            updstb_q, updstb_d;
  logic            err_q, err_d;
  logic [15:0]     count_q, count_d;

  logic            found_hi, found_lo;
  logic [LW-1:0]   sel_hi, sel_lo, sel;

  // Round-robin pick: lowest requester above the last grant, else wrap to the lowest overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        if (LW'(k) > last_q) begin
          found_hi = 1'b1;
          sel_hi   = LW'(k);
        end
        found_lo = 1'b1;
        sel_lo   = LW'(k);
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    addr_d   = addr_q;
    chan_d   = chan_q;
    value_d  = value_q;
    upd_d    = upd_q;
    wr_d     = 1'b0;
    updstb_d = 1'b0;
    err_d    = err_q & ~err_clr_i;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (found_lo && !bus.dac_busy) begin
          for (int k = 0; k < NREQ; k++) begin
            if (sel == LW'(k)) begin
              gnt_d[k] = 1'b1;
              addr_d   = bus.req_addr[k];
              chan_d   = bus.req_chan[6*k +: 6];
              value_d  = bus.req_value[12*k +: 12];
              upd_d    = bus.req_update[k];
            end
          end
          last_d  = sel;
          state_d = S_WR;
        end
      end
      S_WR: begin
        wr_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.dac_busy) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.dac_busy) begin
          count_d = count_q + 16'd1;
          state_d = upd_q ? S_UPD : S_IDLE;
        end
      end
      S_UPD: begin
        updstb_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_UPD_HI;
      end
      S_UPD_HI: begin
        if (bus.dac_busy) begin
          state_d = S_UPD_LO;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_UPD_LO: begin
        if (!bus.dac_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      last_q   <= LW'(NREQ - 1);
      cnt_q    <= '0;
      gnt_q    <= '0;
      addr_q   <= 1'b0;
      chan_q   <= '0;
      value_q  <= '0;
      upd_q    <= 1'b0;
      wr_q     <= 1'b0;
      updstb_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      chan_q   <= chan_d;
      value_q  <= value_d;
      upd_q    <= upd_d;
      wr_q     <= wr_d;
      updstb_q <= updstb_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.dac_addr   = addr_q;
  assign bus.dac_chan   = chan_q;
  assign bus.dac_value  = value_q;
  assign bus.dac_wr     = wr_q;
  assign bus.dac_update = updstb_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q != S_IDLE);
  assign wr_count_o     = count_q;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/ritc_dac_servo_arbiter.md
# ritc_dac_servo_arbiter

Round-robin arbiter and sequencer that shares the single RITC DAC loader port between several independent requesters: the two phase-scanner servo loops (RITC0, RITC1) and software writes from GLITCBUS. It sits between those requesters and `RITC_Dual_DAC`'s load port, all in the `gb_clk` domain. It serializes each write plus optional latch (update), waits on the loader's busy handshake, and flags loader timeouts.

## Interface
- `NREQ`, 3: number of requesters; index 0 has highest priority after reset.
- `TIMEOUT`, 15: max cycles to wait for `dac_busy_i` to rise after a strobe (4-bit counter).
- `clk_i` in 1: GLITCBUS clock (`gb_clk`). One clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `req_i` in NREQ: request k pending; held until `gnt_o[k]`.
- `req_addr_i` in NREQ: per-requester RITC select (0 = RITC0, 1 = RITC1).
- `req_chan_i` in 6*NREQ: per-requester DAC channel, slice [6k+:6].
- `req_value_i` in 12*NREQ: per-requester DAC value, slice [12k+:12].
- `req_update_i` in NREQ: latch DAC outputs after this write.
- `gnt_o` out NREQ: one-cycle pulse; request data captured this cycle.
- `dac_addr_o` out 1, `dac_chan_o` out 6, `dac_value_o` out 12: registered command to loader.
- `dac_wr_o` out 1: one-cycle write strobe.
- `dac_update_o` out 1: one-cycle latch strobe.
- `dac_busy_i` in 1: loader busy.
- `err_clr_i` in 1: clears `err_o`.
- `err_o` out 1: sticky timeout flag.
- `busy_o` out 1: arbiter not in IDLE.
- `wr_count_o` out 16: completed writes, wraps at 0xFFFF→0.

## Operation
- States: IDLE, WR, WAIT_HI, WAIT_LO, UPD, UPD_HI, UPD_LO.
- IDLE: if `dac_busy_i`=0 and any `req_i`, choose first requesting index searching from `last+1` modulo NREQ. Capture addr/chan/value/update into output registers. Pulse `gnt_o[k]`, set `last`=k, go to WR. If `dac_busy_i`=1, no grant.
- WR: `dac_wr_o`=1 for one cycle, clear timeout counter, go to WAIT_HI.
- WAIT_HI: when `dac_busy_i`=1, go to WAIT_LO. Otherwise increment counter. On reaching TIMEOUT, set `err_o` and go to IDLE with no count increment and no update.
- WAIT_LO: when `dac_busy_i`=0, increment `wr_count_o`. Go to UPD if captured update=1, else IDLE.
- UPD/UPD_HI/UPD_LO: same as WR/WAIT_HI/WAIT_LO but strobe `dac_update_o`. Address fields are unchanged. Completion does not increment `wr_count_o`. Timeout sets `err_o` and returns to IDLE.
- `err_clr_i` and a new timeout in the same cycle: set wins.
- A request dropped before grant is simply skipped; it is never granted retroactively.
- Requests arriving during a transaction wait; there is no queueing beyond `req_i` itself.

## Timing
- Reset values: all outputs 0. State IDLE. `last`=NREQ-1, so requester 0 wins first. Timeout counter 0.
- Reset asserted mid-transaction aborts immediately: no strobe completes, and the grant is considered consumed.
- Grant latency: `gnt_o` is asserted the cycle after `req_i` is sampled high in IDLE. `dac_wr_o` follows 1 cycle after `gnt_o`.
- `dac_*` data registers are stable from the `gnt_o` cycle until the next grant.
- Minimum transaction with no update and a loader busy for 1 cycle: IDLE→WR→WAIT_HI→WAIT_LO→IDLE, 4 cycles. The next grant can follow immediately.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,2,0,… Worst-case wait is NREQ−1 transactions.

## Test plan
- Single request: after reset, `req_i`=001, chan=5, value=0x7FF, addr=1. Expect `gnt_o`=001 one cycle later and `dac_wr_o` one cycle after that with those values. With busy high 3 cycles, `wr_count_o`=1 and `busy_o` drops.
- Round-robin: hold `req_i`=111. Expect the grant sequence 001,010,100,001 with values per requester.
- Update: `req_update_i`=1. Expect `dac_wr_o`, busy cycle, then `dac_update_o` pulse with the same addr/chan. `wr_count_o` increments by exactly 1.
- Timeout: `dac_busy_i` held 0 after the strobe. Expect `err_o`=1 after 15 wait cycles, return to IDLE, count unchanged. `err_clr_i` clears it. Timeout coincident with `err_clr_i` leaves `err_o`=1.
- Loader busy: `dac_busy_i`=1 in IDLE with `req_i`=010. No grant until busy falls, then grant next cycle.
- Reset mid-WAIT_LO: assert `rst_n_i`=0. All outputs go 0 immediately. After release, `req_i`=111 grants requester 0 first.
